// File: rtl/uart_word_assembler.sv
// uart_word_assembler
// Frames a byte stream of the form SYNC, P0, P1, P2, P3, C (C = P0^P1^P2^P3)
// into a 32-bit word {P0,P1,P2,P3}. Only checksum-verified words reach
// uart_buf, which then holds until the next good packet. Bad checksums,
// inter-byte timeouts and receiver framing errors all drop the partial packet.
// Result pulses are registered and appear one cycle after the checksum byte.
module uart_word_assembler #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [31:0] uart_buf,
  output logic        valid_data,
  output logic        chk_err,
  output logic        timeout_err,
  output logic        busy
);

  // Idle counter sized to hold TIMEOUT_CYCLES-1; it saturates at all-ones.
  localparam int             CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [1:0]       LAST_IDX = 2'd3;
  localparam int               N_LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [7:0]       chk_reg, chk_next;
  logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [31:0]      uart_buf_reg;
  logic             valid_reg, chk_err_reg, timeout_reg;
  logic [31:0]      shadow_word;

  // Qualified events shared by the next-state and output logic
  logic in_pkt;       // FSM is somewhere inside a packet
  logic sync_seen;    // header byte arriving while idle
  logic byte_take;    // a data byte is accepted inside a packet
  logic abort_pkt;    // receiver framing error inside a packet
  logic cnt_expired;  // line has been quiet for the full allowance
  logic chk_match;    // incoming byte equals the running checksum

  // Strobes produced by the output decoder
  logic start_pkt;
  logic shift_en;
  logic load_buf;
  logic bad_chk;
  logic timeout_hit;

  assign in_pkt      = (state_reg != ST_IDLE);
  assign sync_seen   = (state_reg == ST_IDLE) && rx_valid && (rx_byte == SYNC_BYTE);
  assign abort_pkt   = in_pkt && rx_err;
  assign byte_take   = in_pkt && rx_valid && !rx_err;
  // A byte arriving on the last allowed cycle rescues the packet.
  assign cnt_expired = in_pkt && !rx_valid && !rx_err && (idle_cnt_reg == CNT_LAST);
  assign chk_match   = (rx_byte == chk_reg);

  // State register
  always_ff @(posedge i_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; framing errors outrank data, data outranks the timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sync_seen) begin
          state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (abort_pkt) begin
          state_next = ST_IDLE;
        end else if (byte_take) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_CHECK;
          end
        end else if (cnt_expired) begin
          state_next = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (abort_pkt || byte_take || cnt_expired) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: datapath strobes and the next values of the result pulses
  always_comb begin
    start_pkt   = 1'b0;
    shift_en    = 1'b0;
    load_buf    = 1'b0;
    bad_chk     = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        start_pkt = sync_seen;
      end
      ST_PAYLOAD: begin
        shift_en    = byte_take;
        timeout_hit = cnt_expired;
      end
      ST_CHECK: begin
        load_buf    = byte_take && chk_match;
        bad_chk     = byte_take && !chk_match;
        timeout_hit = cnt_expired;
      end
      default: ;
    endcase
  end

  // Running checksum and payload index, restarted by every header byte
  always_comb begin
    chk_next = chk_reg;
    idx_next = idx_reg;
    if (start_pkt) begin
      chk_next = 8'h00;
      idx_next = 2'd0;
    end else if (shift_en) begin
      chk_next = chk_reg ^ rx_byte;
      idx_next = idx_reg + 2'd1;
    end
  end

  // Quiet-line counter: cleared by any byte or by leaving the packet
  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    if ((state_next == ST_IDLE) || rx_valid) begin
      idle_cnt_next = '0;
    end else if (idle_cnt_reg != CNT_MAX) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  // Packet bookkeeping registers
  always_ff @(posedge i_clk or negedge n_rst) begin
    if (!n_rst) begin
      chk_reg      <= 8'h00;
      idx_reg      <= 2'd0;
      idle_cnt_reg <= '0;
    end else begin
      chk_reg      <= chk_next;
      idx_reg      <= idx_next;
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  // Shadow word as four byte lanes; lane 0 takes the newest byte so P0 ends
  // up in the top lane after four shifts.
  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic [7:0] lane_reg;
      logic [7:0] lane_in;

      if (gi == 0) begin : g_first
        assign lane_in = rx_byte;
      end else begin : g_chain
        assign lane_in = g_lane[gi-1].lane_reg;
      end

      // Shift one byte lane; cleared at the start of each packet
      always_ff @(posedge i_clk or negedge n_rst) begin
        if (!n_rst) begin
          lane_reg <= 8'h00;
        end else if (start_pkt) begin
          lane_reg <= 8'h00;
        end else if (shift_en) begin
          lane_reg <= lane_in;
        end
      end

      assign shadow_word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  // Published word and one-cycle result pulses
  always_ff @(posedge i_clk or negedge n_rst) begin
    if (!n_rst) begin
      uart_buf_reg <= 32'h0;
      valid_reg    <= 1'b0;
      chk_err_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      valid_reg   <= load_buf;
      chk_err_reg <= bad_chk;
      timeout_reg <= timeout_hit;
      if (load_buf) begin
        uart_buf_reg <= shadow_word;
      end
    end
  end

  assign uart_buf    = uart_buf_reg;
  assign valid_data  = valid_reg;
  assign chk_err     = chk_err_reg;
  assign timeout_err = timeout_reg;
  assign busy        = in_pkt;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: expected result events are queued
// as packets are driven and matched against pulses seen at the outputs.
module tb_uart_word_assembler;

  localparam int         TO   = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  localparam logic [2:0] EV_VALID = 3'b001;
  localparam logic [2:0] EV_CHK   = 3'b010;
  localparam logic [2:0] EV_TO    = 3'b100;

  typedef struct packed {
    logic [2:0]  kind;   // {timeout_err, chk_err, valid_data}
    logic [31:0] word;   // uart_buf while the pulse is high
  } evt_t;

  logic        i_clk = 1'b0;
  logic        n_rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;
  logic [31:0] uart_buf;
  logic        valid_data;
  logic        chk_err;
  logic        timeout_err;
  logic        busy;

  evt_t        exp_q[$];
  evt_t        obs_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] last_good = 32'h0;

  always #5 i_clk = ~i_clk;

  uart_word_assembler #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (i_clk),
    .n_rst       (n_rst),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .uart_buf    (uart_buf),
    .valid_data  (valid_data),
    .chk_err     (chk_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // Record every result pulse, sampled mid-cycle
  always @(negedge i_clk) begin
    evt_t o;
    if (n_rst && (valid_data || chk_err || timeout_err)) begin
      o.kind = {timeout_err, chk_err, valid_data};
      o.word = uart_buf;
      obs_q.push_back(o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic [31:0] word);
    evt_t e;
    e.kind = kind;
    e.word = word;
    exp_q.push_back(e);
  endtask

  // Full packet; the model decides between a good word and a checksum drop
  task automatic send_pkt(input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3,
                          input logic [7:0] c);
    logic [7:0] sum;
    sum = p0 ^ p1 ^ p2 ^ p3;
    if (c == sum) begin
      last_good = {p0, p1, p2, p3};
      push_exp(EV_VALID, last_good);
    end else begin
      push_exp(EV_CHK, last_good);
    end
    $display("pkt %h %h %h %h chk %h -> %s", p0, p1, p2, p3, c,
             (c == sum) ? "accept" : "drop");
    send_byte(SYNC);
    send_byte(p0);
    send_byte(p1);
    send_byte(p2);
    send_byte(p3);
    send_byte(c);
  endtask

  // Drain expected events against observed ones, then look for strays
  task automatic expect_events();
    evt_t e;
    evt_t o;
    int   waited;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      while (obs_q.size() == 0 && waited < 40) begin
        @(posedge i_clk);
        #1;
        waited++;
      end
      n_vec++;
      assert (obs_q.size() != 0) else begin
        n_miss++;
        $error("FAIL evt_wait: got no event, expected kind %b word %h", e.kind, e.word);
      end
      if (obs_q.size() != 0) begin
        o = obs_q.pop_front();
        check("evt_kind", 32'(o.kind), 32'(e.kind));
        check("evt_word", o.word, e.word);
      end
    end
    idle(3);
    check("evt_extra", 32'(obs_q.size()), 32'd0);
  endtask

  initial begin
    n_rst    = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    idle(3);

    // Reset state
    check("rst_buf",   uart_buf, 32'h0);
    check("rst_valid", 32'(valid_data), 32'd0);
    check("rst_chk",   32'(chk_err), 32'd0);
    check("rst_to",    32'(timeout_err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    n_rst = 1'b1;
    idle(2);

    // Good packet: result one cycle after the checksum byte, single pulse
    send_pkt(8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    check("good_valid", 32'(valid_data), 32'd1);
    check("good_buf",   uart_buf, 32'h12345678);
    check("good_busy",  32'(busy), 32'd0);
    idle(1);
    check("good_pulse_len", 32'(valid_data), 32'd0);
    expect_events();

    // Bad checksum keeps the previous word
    send_pkt(8'h12, 8'h34, 8'h56, 8'h78, 8'h09);
    check("bad_chk",   32'(chk_err), 32'd1);
    check("bad_valid", 32'(valid_data), 32'd0);
    check("bad_buf",   uart_buf, 32'h12345678);
    expect_events();

    // Inter-byte timeout after P0, then a fresh packet
    $display("pkt %h %h then quiet line", SYNC, 8'h12);
    send_byte(SYNC);
    send_byte(8'h12);
    push_exp(EV_TO, last_good);
    idle(TO - 1);
    check("to_busy_before", 32'(busy), 32'd1);
    check("to_early",       32'(timeout_err), 32'd0);
    idle(1);
    check("to_pulse", 32'(timeout_err), 32'd1);
    check("to_busy",  32'(busy), 32'd0);
    expect_events();
    send_pkt(8'h00, 8'h00, 8'h00, 8'h01, 8'h01);
    check("after_to_buf", uart_buf, 32'h00000001);
    expect_events();

    // Byte arriving on the last allowed cycle rescues the packet
    $display("pkt %h %h <gap> %h %h %h chk %h -> accept", SYNC, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08);
    send_byte(SYNC);
    send_byte(8'h12);
    idle(TO - 1);
    send_byte(8'h34);
    check("edge_no_to", 32'(timeout_err), 32'd0);
    check("edge_busy",  32'(busy), 32'd1);
    last_good = 32'h12345678;
    push_exp(EV_VALID, last_good);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h08);
    check("edge_buf", uart_buf, 32'h12345678);
    expect_events();

    // Sync value as payload: checksum 00 against A5 drops, 00 accepts
    send_pkt(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    check("sync_data_chk", 32'(chk_err), 32'd1);
    expect_events();
    send_pkt(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00);
    check("sync_data_buf", uart_buf, 32'hA5A5A5A5);
    expect_events();

    // Framing error after P1 beats a simultaneous byte; silent abort
    $display("pkt %h %h %h then rx_err", SYNC, 8'h11, 8'h22);
    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_err   = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h33;
    @(posedge i_clk);
    #1;
    rx_err   = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    check("err_busy", 32'(busy), 32'd0);
    send_byte(8'h44);
    send_byte(8'h00);
    check("err_buf", uart_buf, 32'hA5A5A5A5);
    expect_events();

    // Asynchronous reset after P2; leftovers ignored, next packet accepted
    $display("pkt %h %h %h %h then reset", SYNC, 8'h12, 8'h34, 8'h56);
    send_byte(SYNC);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    n_rst = 1'b0;
    #2;
    check("arst_buf",  uart_buf, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pulses", 32'({valid_data, chk_err, timeout_err}), 32'd0);
    last_good = 32'h0;
    idle(1);
    n_rst = 1'b1;
    idle(1);
    send_byte(8'h78);
    send_byte(8'h08);
    check("arst_idle", 32'(busy), 32'd0);
    send_pkt(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22);
    check("arst_good_buf", uart_buf, 32'hDEADBEEF);
    expect_events();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
